// File: rtl/life_game_scheduler_pkg.sv
// Shared constants, state encoding and speed-to-period helper for the
// Game of Life generation scheduler.
package life_game_scheduler_pkg;

  localparam int MAX_LEVEL     = 7;
  localparam int DEFAULT_LEVEL = 3;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ARMED  = 2'd2,
    STEP   = 2'd3
  } sched_state_e;

  typedef logic [MAX_LEVEL:0] frame_cnt_t;

  // Bit positions inside the rising-edge detector vector
  localparam int E_RUN    = 0;
  localparam int E_STEP   = 1;
  localparam int E_FASTER = 2;
  localparam int E_SLOWER = 3;
  localparam int E_EDIT   = 4;

  // Terminal frame count for a level: 2^(MAX_LEVEL - level) - 1
  function automatic frame_cnt_t period_m1(input logic [2:0] level);
    frame_cnt_t p;
    p = frame_cnt_t'(1);
    p = p << (3'(MAX_LEVEL) - level);
    return p - frame_cnt_t'(1);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Vector rising-edge detector; history is cleared by reset so an input held
// high through reset produces one edge right after release.
module rise_edge_detect #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clock) begin
    if (reset) hist_q <= '0;
    else       hist_q <= sig_i;
  end

  assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/life_game_scheduler.sv
// Generation scheduler and edit arbiter: issues step pulses inside vertical
// blanking and never lets a step and a cell edit share a cycle.
module life_game_scheduler
  import life_game_scheduler_pkg::*;
#(
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 btn_run,
  input  logic                 btn_step,
  input  logic                 btn_faster,
  input  logic                 btn_slower,
  input  logic                 frame_start,
  input  logic                 edit_req,
  output logic                 step_enable,
  output logic                 edit_grant,
  output logic                 running,
  output logic [2:0]           speed_level,
  output logic [GEN_WIDTH-1:0] generation_count
);

  logic [4:0] rise;

  sched_state_e         state_q, state_d;
  sched_state_e         ret_q, ret_d;
  frame_cnt_t           frame_cnt_q, frame_cnt_d;
  logic [2:0]           level_q, level_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 step_q, step_d;
  logic                 grant_q, grant_d;
  logic                 running_q, running_d;

  rise_edge_detect #(.WIDTH(5)) u_edges (
    .clock  (clock),
    .reset  (reset),
    .sig_i  ({edit_req, btn_slower, btn_faster, btn_step, btn_run}),
    .rise_o (rise)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    frame_cnt_d = frame_cnt_q;
    level_d     = level_q;
    gen_d       = gen_q;
    step_d      = 1'b0;
    grant_d     = rise[E_EDIT];

    if (rise[E_FASTER] && !rise[E_SLOWER] && level_q != 3'(MAX_LEVEL))
      level_d = level_q + 3'd1;
    else if (rise[E_SLOWER] && !rise[E_FASTER] && level_q != 3'd0)
      level_d = level_q - 3'd1;

    case (state_q)
      PAUSED: begin
        if (rise[E_RUN]) begin
          state_d     = RUN;
          frame_cnt_d = '0;
        end else if (rise[E_STEP]) begin
          state_d = ARMED;
          ret_d   = PAUSED;
        end
      end
      RUN: begin
        if (rise[E_RUN]) begin
          state_d = PAUSED;
        end else if (frame_start) begin
          // >= so a speed-up past the current count still fires next frame
          if (frame_cnt_q >= period_m1(level_q)) begin
            frame_cnt_d = '0;
            state_d     = STEP;
            ret_d       = RUN;
          end else begin
            frame_cnt_d = frame_cnt_q + frame_cnt_t'(1);
          end
        end
      end
      ARMED: begin
        if (frame_start) state_d = STEP;
      end
      STEP: begin
        if (!rise[E_EDIT]) begin
          step_d  = 1'b1;
          gen_d   = gen_q + GEN_WIDTH'(1);
          state_d = ret_q;
        end
      end
      default: state_d = PAUSED;
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PAUSED;
      ret_q       <= PAUSED;
      frame_cnt_q <= '0;
      level_q     <= 3'(DEFAULT_LEVEL);
      gen_q       <= '0;
      step_q      <= 1'b0;
      grant_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      frame_cnt_q <= frame_cnt_d;
      level_q     <= level_d;
      gen_q       <= gen_d;
      step_q      <= step_d;
      grant_q     <= grant_d;
      running_q   <= running_d;
    end
  end

  assign step_enable      = step_q;
  assign edit_grant       = grant_q;
  assign running          = running_q;
  assign speed_level      = level_q;
  assign generation_count = gen_q;

endmodule

// File: tb/tb_life_game_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the scheduler rules.
module tb_life_game_scheduler;

  localparam int GW   = 10;
  localparam int GMAX = (1 << GW) - 1;

  logic          clock;
  logic          reset;
  logic          btn_run, btn_step, btn_faster, btn_slower;
  logic          frame_start, edit_req;
  logic          step_enable, edit_grant, running;
  logic [2:0]    speed_level;
  logic [GW-1:0] generation_count;

  int n_tests = 0;
  int n_fail  = 0;

  life_game_scheduler #(.GEN_WIDTH(GW)) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_run          (btn_run),
    .btn_step         (btn_step),
    .btn_faster       (btn_faster),
    .btn_slower       (btn_slower),
    .frame_start      (frame_start),
    .edit_req         (edit_req),
    .step_enable      (step_enable),
    .edit_grant       (edit_grant),
    .running          (running),
    .speed_level      (speed_level),
    .generation_count (generation_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode is one of "paused", "playing", "waiting for a
  // frame to do a single step", "owing a step"; time is counted in frames.
  bit  model_valid = 0;
  int  m_mode;          // 0 paused, 1 playing, 2 waiting frame, 3 owing step
  int  m_after;         // mode to resume after an owed step
  int  m_frames;
  int  m_level;
  int  exp_gen;
  bit  exp_step, exp_grant, exp_running;
  bit  p_run, p_step, p_fast, p_slow, p_edit;
  bit  e_run, e_step, e_fast, e_slow, e_edit;
  int  period;

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_after = 0; m_frames = 0; m_level = 3; exp_gen = 0;
      exp_step = 0; exp_grant = 0; exp_running = 0;
      p_run = 0; p_step = 0; p_fast = 0; p_slow = 0; p_edit = 0;
      model_valid = 1;
    end else begin
      e_run  = btn_run    && !p_run;
      e_step = btn_step   && !p_step;
      e_fast = btn_faster && !p_fast;
      e_slow = btn_slower && !p_slow;
      e_edit = edit_req   && !p_edit;
      period = 2 ** (7 - m_level);
      exp_grant = e_edit;
      exp_step  = 0;
      if (m_mode == 0) begin
        if (e_run) begin m_mode = 1; m_frames = 0; end
        else if (e_step) begin m_mode = 2; m_after = 0; end
      end else if (m_mode == 1) begin
        if (e_run) m_mode = 0;
        else if (frame_start) begin
          if (m_frames >= period - 1) begin m_frames = 0; m_mode = 3; m_after = 1; end
          else m_frames = m_frames + 1;
        end
      end else if (m_mode == 2) begin
        if (frame_start) m_mode = 3;
      end else begin
        if (!e_edit) begin
          exp_step = 1;
          exp_gen  = (exp_gen + 1) % (GMAX + 1);
          m_mode   = m_after;
        end
      end
      if (e_fast && !e_slow) m_level = (m_level < 7) ? m_level + 1 : 7;
      else if (e_slow && !e_fast) m_level = (m_level > 0) ? m_level - 1 : 0;
      exp_running = (m_mode == 1);
      p_run = btn_run; p_step = btn_step; p_fast = btn_faster;
      p_slow = btn_slower; p_edit = edit_req;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (model_valid) begin
      check("step_enable", step_enable, exp_step);
      check("edit_grant", edit_grant, exp_grant);
      check("running", running, exp_running);
      check("speed_level", speed_level, m_level);
      check("generation_count", generation_count, exp_gen);
      n_tests++;
      if (step_enable === 1'b1 && edit_grant === 1'b1) begin
        n_fail++;
        $display("FAIL overlap: step_enable and edit_grant both 1 (t=%0t)", $time);
      end
    end
  end

  task automatic press_run();
    btn_run = 1; @(negedge clock); btn_run = 0; @(negedge clock);
  endtask
  task automatic press_step();
    btn_step = 1; @(negedge clock); btn_step = 0; @(negedge clock);
  endtask
  task automatic press_faster();
    btn_faster = 1; @(negedge clock); btn_faster = 0; @(negedge clock);
  endtask
  task automatic press_slower();
    btn_slower = 1; @(negedge clock); btn_slower = 0; @(negedge clock);
  endtask
  task automatic frame_gap();
    frame_start = 1; @(negedge clock); frame_start = 0; repeat (2) @(negedge clock);
  endtask

  int guard;
  int gen_snap;

  initial begin
    reset = 1; btn_run = 0; btn_step = 0; btn_faster = 0; btn_slower = 0;
    frame_start = 0; edit_req = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    check("t0_level", speed_level, 3);
    check("t0_gen", generation_count, 0);
    check("t0_running", running, 0);
    check("t0_step", step_enable, 0);

    // 1: held run button, period 16
    btn_run = 1; repeat (3) @(negedge clock); btn_run = 0; @(negedge clock);
    check("t1_running", running, 1);
    for (int i = 1; i <= 64; i++) begin
      frame_start = 1; @(negedge clock); frame_start = 0;
      check("t1_step_n1", step_enable, 0);
      @(negedge clock);
      check("t1_step_n2", step_enable, (i % 16 == 0));
      repeat (2) @(negedge clock);
    end
    check("t1_gen", generation_count, 4);
    check("t1_still_running", running, 1);

    // 2: single step from pause
    press_run();
    check("t2_paused", running, 0);
    press_step();
    repeat (9) @(negedge clock);
    frame_start = 1; @(negedge clock); frame_start = 0;
    check("t2_step_n1", step_enable, 0);
    @(negedge clock);
    check("t2_step_n2", step_enable, 1);
    @(negedge clock);
    check("t2_gen", generation_count, 5);
    check("t2_running", running, 0);
    repeat (40) frame_gap();
    check("t2_gen_hold", generation_count, 5);

    // 3: edit conflicting with a step
    press_run();
    check("t3_running", running, 1);
    repeat (15) frame_gap();
    frame_start = 1; edit_req = 1; @(negedge clock); frame_start = 0;
    check("t3a_grant_n1", edit_grant, 1);
    check("t3a_step_n1", step_enable, 0);
    @(negedge clock);
    check("t3a_step_n2", step_enable, 1);
    check("t3a_grant_n2", edit_grant, 0);
    edit_req = 0; repeat (2) @(negedge clock);
    repeat (15) frame_gap();
    frame_start = 1; @(negedge clock); frame_start = 0; edit_req = 1;
    @(negedge clock);
    check("t3b_grant_n2", edit_grant, 1);
    check("t3b_step_n2", step_enable, 0);
    @(negedge clock);
    check("t3b_step_n3", step_enable, 1);
    check("t3b_grant_n3", edit_grant, 0);
    edit_req = 0; @(negedge clock);
    check("t3_gen", generation_count, 7);

    // 4: speed saturation
    repeat (6) press_faster();
    check("t4_level_max", speed_level, 7);
    for (int i = 0; i < 5; i++) begin
      frame_start = 1; @(negedge clock); frame_start = 0;
      check("t4_step_n1", step_enable, 0);
      @(negedge clock);
      check("t4_step_n2", step_enable, 1);
      @(negedge clock);
    end
    check("t4_gen", generation_count, 12);
    btn_faster = 1; btn_slower = 1; @(negedge clock);
    btn_faster = 0; btn_slower = 0; @(negedge clock);
    check("t4_both", speed_level, 7);
    repeat (9) press_slower();
    check("t4_level_min", speed_level, 0);
    repeat (7) press_faster();
    check("t4_level_back", speed_level, 7);

    // 6: reset landing on the STEP cycle
    press_run();
    press_step();
    frame_start = 1; @(negedge clock); frame_start = 0;
    gen_snap = exp_gen;
    check("t6_gen_unchanged", generation_count, gen_snap);
    check("t6_step_n1", step_enable, 0);
    reset = 1; @(negedge clock);
    check("t6_step", step_enable, 0);
    check("t6_gen", generation_count, 0);
    check("t6_running", running, 0);
    check("t6_level", speed_level, 3);
    reset = 0;
    frame_gap();
    check("t6_no_pending", generation_count, 0);

    // 5: counter wrap
    repeat (4) press_faster();
    press_run();
    guard = 0;
    while (exp_gen != GMAX && guard < 5000) begin
      frame_start = 1; @(negedge clock); guard++;
    end
    frame_start = 0;
    n_tests++;
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL t5_timeout: %0d cycles without reaching %0d", guard, GMAX);
    end
    check("t5_gen_max", generation_count, GMAX);
    @(negedge clock);
    press_run();
    press_step();
    frame_start = 1; @(negedge clock); frame_start = 0;
    @(negedge clock);
    check("t5_step", step_enable, 1);
    check("t5_wrap", generation_count, 0);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      btn_run     = ($urandom_range(0, 11) == 0);
      btn_step    = ($urandom_range(0, 5) == 0);
      btn_faster  = ($urandom_range(0, 9) == 0);
      btn_slower  = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 2) == 0);
      edit_req    = ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    reset = 0; btn_run = 0; btn_step = 0; btn_faster = 0; btn_slower = 0;
    frame_start = 0; edit_req = 0;
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
